// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared constants, register map and state encoding for the UART command decoder
package uart_cmd_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam logic [7:0] ADDR_FREQ = 8'h00;
  localparam logic [7:0] ADDR_AMP  = 8'h01;
  localparam logic [7:0] ADDR_CTRL = 8'h02;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_CSUM = 2'd3
  } state_t;

  function automatic logic addr_valid(input logic [7:0] a);
    return a <= ADDR_CTRL;
  endfunction

endpackage

// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - frames UART bytes (A5, ADDR, D3..D0, XOR CSUM) into DDS control register writes
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int CLK_FREQ       = 100000000,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [31:0] freq_word,
  output logic [15:0] amp,
  output logic        tx_en,
  output logic        sideband,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [7:0]  err_count
);

  localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);

  if (CLK_FREQ < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("uart_cmd_ctrl: CLK_FREQ and TIMEOUT_CYCLES must be positive");
  end

  state_t           r_state;
  logic [1:0]       r_idx;
  logic [7:0]       r_addr;
  logic [31:0]      r_data;
  logic [7:0]       r_xor;
  logic [GAP_W-1:0] r_gap;
  logic [31:0]      r_freq_word;
  logic [15:0]      r_amp;
  logic             r_tx_en;
  logic             r_sideband;
  logic             r_frame_ok;
  logic             r_frame_err;
  logic [7:0]       r_err_count;

  logic w_csum_byte;
  logic w_timeout;
  logic w_accept;
  logic w_reject;

  // A strobe in the same cycle always beats the timeout, so the byte is never lost.
  assign w_timeout   = (r_state != ST_IDLE) && !rx_valid && (r_gap == GAP_LAST);
  assign w_csum_byte = (r_state == ST_CSUM) && rx_valid;
  assign w_accept    = w_csum_byte && (rx_data == r_xor) && addr_valid(r_addr);
  assign w_reject    = (w_csum_byte && !w_accept) || w_timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_idx       <= 2'd0;
      r_addr      <= 8'h00;
      r_data      <= 32'h0;
      r_xor       <= 8'h00;
      r_gap       <= '0;
      r_freq_word <= 32'h0;
      r_amp       <= 16'h0;
      r_tx_en     <= 1'b0;
      r_sideband  <= 1'b0;
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
      r_err_count <= 8'h00;
    end else begin
      r_frame_ok  <= w_accept;
      r_frame_err <= w_reject;

      if (w_reject && r_err_count != 8'hFF) begin
        r_err_count <= r_err_count + 8'd1;
      end

      if (w_accept) begin
        case (r_addr)
          ADDR_FREQ: r_freq_word <= r_data;
          ADDR_AMP:  r_amp       <= r_data[15:0];
          ADDR_CTRL: begin
            r_tx_en    <= r_data[0];
            r_sideband <= r_data[1];
          end
          default: ;
        endcase
      end

      if (r_state == ST_IDLE || rx_valid || w_timeout) begin
        r_gap <= '0;
      end else begin
        r_gap <= r_gap + GAP_W'(1);
      end

      case (r_state)
        ST_IDLE: begin
          if (rx_valid && rx_data == SYNC_BYTE) begin
            r_state <= ST_ADDR;
            r_xor   <= 8'h00;
          end
        end
        ST_ADDR: begin
          if (rx_valid) begin
            r_addr  <= rx_data;
            r_xor   <= rx_data;
            r_idx   <= 2'd0;
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          // Sync bytes here are payload; there is deliberately no resynchronisation.
          if (rx_valid) begin
            r_data <= {r_data[23:0], rx_data};
            r_xor  <= r_xor ^ rx_data;
            r_idx  <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
              r_state <= ST_CSUM;
            end
          end
        end
        ST_CSUM: begin
          if (rx_valid) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_timeout) begin
        r_state <= ST_IDLE;
      end
    end
  end

  assign freq_word = r_freq_word;
  assign amp       = r_amp;
  assign tx_en     = r_tx_en;
  assign sideband  = r_sideband;
  assign frame_ok  = r_frame_ok;
  assign frame_err = r_frame_err;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb/tb_uart_cmd_ctrl.sv - randomized self-checking bench for uart_cmd_ctrl against a frame-level model
module tb_uart_cmd_ctrl;

  localparam int TO = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [31:0] freq_word;
  logic [15:0] amp;
  logic        tx_en;
  logic        sideband;
  logic        frame_ok;
  logic        frame_err;
  logic [7:0]  err_count;

  uart_cmd_ctrl #(.CLK_FREQ(100000000), .TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .freq_word (freq_word),
    .amp       (amp),
    .tx_en     (tx_en),
    .sideband  (sideband),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int ok_seen = 0;
  int err_seen = 0;
  int both_seen = 0;

  logic [31:0] m_freq;
  logic [15:0] m_amp;
  logic        m_tx;
  logic        m_sb;
  logic [7:0]  m_err;

  always @(posedge clk) begin
    #1;
    if (frame_ok) ok_seen++;
    if (frame_err) err_seen++;
    if (frame_ok && frame_err) both_seen++;
  end

  function automatic void model_reset();
    m_freq = 32'h0; m_amp = 16'h0; m_tx = 1'b0; m_sb = 1'b0; m_err = 8'h0;
  endfunction

  function automatic void model_error();
    if (m_err != 8'hFF) m_err = m_err + 8'd1;
  endfunction

  function automatic logic [7:0] csum_of(input logic [7:0] a, input logic [31:0] d);
    return a ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
  endfunction

  function automatic bit model_frame(input logic [7:0] a, input logic [31:0] d, input logic [7:0] cs);
    if (cs != csum_of(a, d) || a > 8'h02) begin
      model_error();
      return 1'b0;
    end
    if (a == 8'h00) m_freq = d;
    else if (a == 8'h01) m_amp = d[15:0];
    else begin
      m_tx = d[0];
      m_sb = d[1];
    end
    return 1'b1;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [31:0] d, input logic [7:0] cs, input int max_gap);
    logic [7:0] b [7];
    b[0] = 8'hA5; b[1] = a; b[2] = d[31:24]; b[3] = d[23:16];
    b[4] = d[15:8]; b[5] = d[7:0]; b[6] = cs;
    for (int i = 0; i < 7; i++) begin
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
      send_byte(b[i]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    n_tests++;
    if ({freq_word, amp, tx_en, sideband, frame_ok, frame_err, err_count} !== 59'h0) begin
      $display("FAIL reset_state: got %h %h %b %b %b %b %h want all zero",
               freq_word, amp, tx_en, sideband, frame_ok, frame_err, err_count);
      n_fail++;
    end
  endtask

  task automatic test_freq();
    bit exp;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h12);
    send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    n_tests++;
    if (freq_word !== 32'h0 || frame_ok !== 1'b0) begin
      $display("FAIL freq_before_csum: got freq %h ok %b want 00000000 0", freq_word, frame_ok);
      n_fail++;
    end
    send_byte(8'h08);
    exp = model_frame(8'h00, 32'h12345678, 8'h08);
    n_tests++;
    if (frame_ok !== exp || freq_word !== 32'h12345678) begin
      $display("FAIL freq_latency1: got ok %b freq %h want %b 12345678", frame_ok, freq_word, exp);
      n_fail++;
    end
    @(negedge clk);
    n_tests++;
    if (frame_ok !== 1'b0) begin
      $display("FAIL freq_ok_width: got %b want 0", frame_ok);
      n_fail++;
    end
  endtask

  task automatic test_ctrl_amp();
    bit exp;
    send_frame(8'h02, 32'h00000003, 8'h01, 0);
    exp = model_frame(8'h02, 32'h00000003, 8'h01);
    n_tests++;
    if (frame_ok !== exp || tx_en !== 1'b1 || sideband !== 1'b1) begin
      $display("FAIL ctrl_write: got ok %b tx %b sb %b want %b 1 1", frame_ok, tx_en, sideband, exp);
      n_fail++;
    end
    send_frame(8'h01, 32'h00008000, 8'h81, 0);
    exp = model_frame(8'h01, 32'h00008000, 8'h81);
    n_tests++;
    if (frame_ok !== exp || amp !== 16'h8000) begin
      $display("FAIL amp_write: got ok %b amp %h want %b 8000", frame_ok, amp, exp);
      n_fail++;
    end
  endtask

  task automatic test_bad_csum();
    bit exp;
    send_frame(8'h00, 32'h12345678, 8'h09, 0);
    exp = model_frame(8'h00, 32'h12345678, 8'h09);
    n_tests++;
    if (frame_err !== !exp || frame_ok !== exp ||
        {freq_word, err_count} !== {m_freq, m_err}) begin
      $display("FAIL bad_csum: got err %b ok %b freq %h cnt %0d want %b %b %h %0d",
               frame_err, frame_ok, freq_word, err_count, !exp, exp, m_freq, m_err);
      n_fail++;
    end
  endtask

  task automatic test_timeout();
    int first = 0;
    int pulses = 0;
    bit exp;
    logic [31:0] d;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h12);
    for (int j = 1; j <= TO + 10; j++) begin
      @(negedge clk);
      if (frame_err) begin
        pulses++;
        if (first == 0) first = j;
      end
    end
    model_error();
    n_tests++;
    if (first != TO || pulses != 1 || err_count !== m_err) begin
      $display("FAIL timeout: got at %0d pulses %0d cnt %0d want at %0d pulses 1 cnt %0d",
               first, pulses, err_count, TO, m_err);
      n_fail++;
    end
    d = $urandom;
    send_frame(8'h00, d, csum_of(8'h00, d), 0);
    exp = model_frame(8'h00, d, csum_of(8'h00, d));
    n_tests++;
    if (frame_ok !== exp || freq_word !== m_freq) begin
      $display("FAIL after_timeout: got ok %b freq %h want %b %h", frame_ok, freq_word, exp, m_freq);
      n_fail++;
    end
  endtask

  task automatic test_priority();
    int e0;
    bit exp;
    logic [7:0] b [7];
    e0 = err_seen;
    b[0] = 8'hA5; b[1] = 8'h00; b[2] = 8'hCA; b[3] = 8'hFE;
    b[4] = 8'hBA; b[5] = 8'hBE; b[6] = csum_of(8'h00, 32'hCAFEBABE);
    send_byte(b[0]);
    for (int i = 1; i < 7; i++) begin
      repeat (TO - 1) @(negedge clk);
      send_byte(b[i]);
    end
    exp = model_frame(8'h00, 32'hCAFEBABE, b[6]);
    @(negedge clk);
    n_tests++;
    if (err_seen != e0 || freq_word !== m_freq || !exp) begin
      $display("FAIL rx_beats_timeout: got errs %0d freq %h want 0 %h", err_seen - e0, freq_word, m_freq);
      n_fail++;
    end
  endtask

  task automatic test_mid_a5();
    bit exp;
    send_frame(8'h00, 32'hA5A5A5A5, 8'h00, 0);
    exp = model_frame(8'h00, 32'hA5A5A5A5, 8'h00);
    n_tests++;
    if (frame_ok !== exp || freq_word !== m_freq) begin
      $display("FAIL mid_frame_sync: got ok %b freq %h want %b %h", frame_ok, freq_word, exp, m_freq);
      n_fail++;
    end
  endtask

  task automatic test_noise_bad_addr();
    int e0;
    bit exp;
    e0 = err_seen;
    send_byte(8'h11); send_byte(8'h22);
    send_frame(8'h03, 32'h0, 8'h03, 0);
    exp = model_frame(8'h03, 32'h0, 8'h03);
    @(negedge clk);
    n_tests++;
    if (err_seen - e0 != 1 || exp ||
        {freq_word, amp, tx_en, sideband, err_count} !== {m_freq, m_amp, m_tx, m_sb, m_err}) begin
      $display("FAIL noise_bad_addr: got errs %0d regs %h %h %b %b %0d want 1 %h %h %b %b %0d",
               err_seen - e0, freq_word, amp, tx_en, sideband, err_count,
               m_freq, m_amp, m_tx, m_sb, m_err);
      n_fail++;
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 40; f++) begin
      logic [7:0] a, cs, nb;
      logic [31:0] d;
      bit exp;
      int gap;
      repeat ($urandom_range(0, 2)) begin
        nb = 8'($urandom);
        if (nb == 8'hA5) nb = 8'h5A;
        send_byte(nb);
      end
      a = 8'($urandom_range(0, 3));
      d = $urandom;
      cs = csum_of(a, d);
      if ($urandom_range(0, 3) == 0) cs = cs ^ 8'($urandom_range(1, 255));
      gap = ($urandom_range(0, 3) == 0) ? TO - 1 : 0;
      send_frame(a, d, cs, gap);
      exp = model_frame(a, d, cs);
      n_tests++;
      if (frame_ok !== exp || frame_err !== !exp ||
          {freq_word, amp, tx_en, sideband, err_count} !== {m_freq, m_amp, m_tx, m_sb, m_err}) begin
        $display("FAIL random_frame%0d: got ok %b err %b regs %h %h %b %b %0d want %b %b %h %h %b %b %0d",
                 f, frame_ok, frame_err, freq_word, amp, tx_en, sideband, err_count,
                 exp, !exp, m_freq, m_amp, m_tx, m_sb, m_err);
        n_fail++;
      end
    end
  endtask

  task automatic test_saturate();
    for (int f = 0; f < 300; f++) begin
      logic [31:0] d;
      bit exp;
      d = $urandom;
      send_frame(8'h00, d, ~csum_of(8'h00, d), 0);
      exp = model_frame(8'h00, d, ~csum_of(8'h00, d));
      if (exp) m_err = 8'h00;
    end
    n_tests++;
    if (err_count !== 8'hFF || m_err !== 8'hFF || freq_word !== m_freq) begin
      $display("FAIL err_saturate: got cnt %0d freq %h want 255 %h", err_count, freq_word, m_freq);
      n_fail++;
    end
  endtask

  task automatic test_rst_midframe();
    int e0;
    bit exp;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h12);
    e0 = err_seen;
    rst = 1'b1;
    rx_data = 8'h34;
    rx_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rx_valid = 1'b0;
    model_reset();
    n_tests++;
    if ({freq_word, amp, tx_en, sideband, frame_ok, frame_err, err_count} !== 59'h0) begin
      $display("FAIL rst_midframe: got %h %h %b %b %b %b %0d want all zero",
               freq_word, amp, tx_en, sideband, frame_ok, frame_err, err_count);
      n_fail++;
    end
    repeat (TO + 10) @(negedge clk);
    n_tests++;
    if (err_seen != e0 || err_count !== 8'h00) begin
      $display("FAIL rst_no_err: got errs %0d cnt %0d want 0 0", err_seen - e0, err_count);
      n_fail++;
    end
    send_frame(8'h01, 32'h0000BEEF, csum_of(8'h01, 32'h0000BEEF), 3);
    exp = model_frame(8'h01, 32'h0000BEEF, csum_of(8'h01, 32'h0000BEEF));
    n_tests++;
    if (frame_ok !== exp || amp !== m_amp) begin
      $display("FAIL after_rst_frame: got ok %b amp %h want %b %h", frame_ok, amp, exp, m_amp);
      n_fail++;
    end
  endtask

  initial begin
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    @(negedge clk);
    test_reset();
    test_freq();
    test_ctrl_amp();
    test_bad_csum();
    test_timeout();
    test_priority();
    test_mid_a5();
    test_noise_bad_addr();
    test_random();
    test_saturate();
    test_rst_midframe();
    @(negedge clk);
    n_tests++;
    if (both_seen != 0) begin
      $display("FAIL ok_err_exclusive: got %0d overlapping cycles want 0", both_seen);
      n_fail++;
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cmd_ctrl.md
UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100000000, system clock in Hz (documentation and timeout derivation only).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 100000, maximum idle clocks allowed between bytes inside a frame.
REQ-003 SHALL have port clk, input, 1 bit, single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have port rx_data, input, 8 bits, received byte from the UART receiver.
REQ-006 SHALL have port rx_valid, input, 1 bit, one-cycle strobe qualifying rx_data.
REQ-007 SHALL have port freq_word, output, 32 bits, DDS tuning word.
REQ-008 SHALL have port amp, output, 16 bits, output amplitude scale.
REQ-009 SHALL have port tx_en, output, 1 bit, DDS output enable.
REQ-010 SHALL have port sideband, output, 1 bit, 0 = USB, 1 = LSB.
REQ-011 SHALL have port frame_ok, output, 1 bit, one-cycle pulse when a frame is accepted.
REQ-012 SHALL have port frame_err, output, 1 bit, one-cycle pulse when a frame is rejected.
REQ-013 SHALL have port err_count, output, 8 bits, count of rejected frames, saturating at 255.

Function
REQ-014 SHALL accept frames of 7 bytes: SYNC 0xA5, ADDR, D3, D2, D1, D0 (big-endian 32-bit), CSUM.
REQ-015 SHALL define CSUM as the XOR of ADDR, D3, D2, D1 and D0.
REQ-016 SHALL implement states IDLE, ADDR, DATA and CSUM, advancing only on cycles where rx_valid=1.
REQ-017 SHALL, in IDLE, move to ADDR on 0xA5 and silently ignore any other byte, with no error.
REQ-018 SHALL, in ADDR, latch the address byte and move to DATA with the byte index cleared to 0.
REQ-019 SHALL, in DATA, shift in four bytes MSB-first and move to CSUM after the fourth.
REQ-020 SHALL keep a running XOR during ADDR and DATA, and compare it in CSUM against the received byte.
REQ-021 SHALL support this register map: addr 0x00 = freq_word[31:0]; 0x01 = amp (takes D1:D0, ignores D3:D2); 0x02 = control (bit0 tx_en, bit1 sideband, other bits ignored).
REQ-022 SHALL, on a checksum match with addr 0x00-0x02, update the target register on the clock edge that samples the CSUM byte, and pulse frame_ok in that same cycle.
REQ-023 SHALL make the new register value and frame_ok visible together, one cycle after the CSUM byte's rx_valid (latency 1).
REQ-024 SHALL, on a checksum mismatch or an addr > 0x02, leave all registers unchanged and pulse frame_err.
REQ-025 SHALL return to IDLE after the CSUM byte in every case.
REQ-026 SHALL, outside IDLE, count clocks since the last rx_valid and clear the count on every rx_valid.
REQ-027 SHALL, when that count reaches TIMEOUT_CYCLES, discard the partial frame, pulse frame_err and return to IDLE.
REQ-028 SHALL give rx_valid priority over timeout when both occur in the same cycle: the byte is processed and the count is cleared.
REQ-029 SHALL treat a 0xA5 received mid-frame as ordinary data, with no resynchronisation.
REQ-030 SHALL increment err_count on each frame_err pulse, holding at 255 without wrapping.
REQ-031 SHALL never assert frame_ok and frame_err in the same cycle.

Reset
REQ-032 SHALL, on rst=1 at a clock edge, set: state IDLE; freq_word 0; amp 0; tx_en 0; sideband 0; frame_ok 0; frame_err 0; err_count 0; byte index, XOR accumulator and gap counter 0.
REQ-033 SHALL, on reset mid-frame, drop the partial frame without pulsing frame_err.
REQ-034 SHALL ignore rx_valid in any cycle where rst=1.

Structure
REQ-035 SHALL place the SYNC byte, register addresses 0x00-0x02 and the state encoding in a shared package, uart_cmd_pkg.
REQ-036 SHALL be a single flat module with no sub-modules; uart_rx is instantiated beside it at top level, not inside it.
REQ-037 SHALL size the gap counter to hold TIMEOUT_CYCLES.

Verification
REQ-038 SHALL cover: A5 00 12 34 56 78 CS=0x08 -> freq_word=0x12345678 and frame_ok one cycle after the CSUM strobe.
REQ-039 SHALL cover: A5 02 00 00 00 03 CS=0x01 -> tx_en=1, sideband=1; then A5 01 00 00 80 00 CS=0x81 -> amp=0x8000.
REQ-040 SHALL cover: A5 00 12 34 56 78 with CS=0x09 -> frame_err pulse, err_count=1, freq_word unchanged.
REQ-041 SHALL cover: A5 00 12 followed by silence with TIMEOUT_CYCLES=50 -> frame_err exactly 50 clocks after the last strobe; then a good frame is accepted.
REQ-042 SHALL cover: bytes 11 22 A5 03 00 00 00 00 CS=0x03 -> only one frame_err (bad address), registers unchanged; 300 bad frames -> err_count=255.
REQ-043 SHALL cover: rst asserted after A5 00 12 -> all outputs reset, no frame_err; then a subsequent good frame is accepted.
